// File: rtl/debounce_ckt.sv
// Push-button debouncer: synchroniser chain plus a stability counter that updates `result`
// only after DEBOUNCE_CYCLES consecutive new-level samples. Edge pulses are enabled by DEBOUNCE_EDGE_EN.
module debounce_ckt #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic result
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic result_rise,
  output logic result_fall
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   b_s;
  logic                   take_new;

  assign b_s = sync[SYNC_STAGES-1];

  // The window is complete on this edge: b_s differs and the counter already holds DEBOUNCE_CYCLES-1 matches.
  assign take_new = (b_s != result) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], button};
    end
  end

  // Any b_s sample that agrees with result throws away partial progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      result <= 1'b0;
    end else if (b_s == result) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      result <= b_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Registered alongside result so each pulse lines up with the cycle result shows its new value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_rise <= 1'b0;
      result_fall <= 1'b0;
    end else begin
      result_rise <= take_new & b_s;
      result_fall <= take_new & ~b_s;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_ckt.sv
// Bench for debounce_ckt: three instances (DEBOUNCE_CYCLES 4, 1, 8) share one button and are
// checked every cycle against a sample-window reference model through an expected queue.
module tb_debounce_ckt;

  localparam int SYNC = 2;
`ifdef DEBOUNCE_EDGE_EN
  localparam int OW = 3;
`else
  localparam int OW = 1;
`endif
  localparam int W = 3 * OW;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic button = 1'b0;
  always #5 clk = ~clk;

  logic y4, y1, y8;
`ifdef DEBOUNCE_EDGE_EN
  logic r4, f4, r1, f1, r8, f8;
`endif
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  bit           samp[$];
  int           ecnt   = 0;
  int           checks = 0;
  int           errors = 0;

  debounce_ckt #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .button(button), .result(y4)
`ifdef DEBOUNCE_EDGE_EN
    , .result_rise(r4), .result_fall(f4)
`endif
  );
  debounce_ckt #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .button(button), .result(y1)
`ifdef DEBOUNCE_EDGE_EN
    , .result_rise(r1), .result_fall(f1)
`endif
  );
  debounce_ckt #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(8)) dut8 (
    .clk(clk), .reset(reset), .button(button), .result(y8)
`ifdef DEBOUNCE_EDGE_EN
    , .result_rise(r8), .result_fall(f8)
`endif
  );

`ifdef DEBOUNCE_EDGE_EN
  assign obs = {f8, r8, y8, f1, r1, y1, f4, r4, y4};
`else
  assign obs = {y8, y1, y4};
`endif

  // ---------------- reference model ----------------
  function automatic int cfg_dc(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  // True when the last dc synchronised samples (button seen SYNC edges ago) all differ from cur.
  function automatic bit all_differ(input int dc, input bit cur);
    int last;
    last = samp.size() - 1 - SYNC;
    for (int j = 0; j < dc; j++) begin
      if (samp[last-j] == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] model_step(input logic [W-1:0] prev);
    logic [W-1:0] r;
    bit cur, chg, nw;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      cur = prev[i*OW];
      chg = all_differ(cfg_dc(i), cur);
      nw  = cur ^ chg;
`ifdef DEBOUNCE_EDGE_EN
      r[i*OW +: OW] = {chg & ~nw, chg & nw, nw};
`else
      r[i*OW] = nw;
`endif
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp.delete();
      for (int j = 0; j < SYNC + 8; j++) samp.push_back(1'b0);
      exp_q.delete();
      last_exp <= '0;
    end else begin
      samp.push_back(button);
      if (samp.size() > 40) void'(samp.pop_front());
      exp_q.push_back(model_step(last_exp));
      last_exp <= model_step(last_exp);
      ecnt <= ecnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic lvl, input int ns);
    button = lvl;
    #(ns);
  endtask

  task automatic align();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    button = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs, {W{1'b0}});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b want %b", obs, {W{1'b0}});
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_press();
    int k_on, k_off, e_rise, e_fall;
    logic [W-1:0] e;
    logic prev4;
`ifdef DEBOUNCE_EDGE_EN
    int n_rise, n_fall;
    n_rise = 0;
    n_fall = 0;
`endif
    k_on = -1; k_off = -1; e_rise = -1; e_fall = -1;
    prev4 = y4;
    fork
      begin
        align();
        button = 1'b1;
        @(posedge clk); #1 k_on = ecnt;
        #85 button = 1'b0;
        @(posedge clk); #1 k_off = ecnt;
      end
      begin
        for (int c = 0; c < 26; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL press_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL press_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if (y4 && !prev4 && e_rise < 0) e_rise = ecnt;
          if (!y4 && prev4 && e_fall < 0) e_fall = ecnt;
          prev4 = y4;
`ifdef DEBOUNCE_EDGE_EN
          if (r4) n_rise++;
          if (f4) n_fall++;
`endif
        end
      end
    join
    checks++;
    if (e_rise - k_on != 5) begin
      errors++; $display("FAIL press_latency: got %0d edges want 5", e_rise - k_on);
    end
    checks++;
    if (e_fall - k_off != 5) begin
      errors++; $display("FAIL release_latency: got %0d edges want 5", e_fall - k_off);
    end
`ifdef DEBOUNCE_EDGE_EN
    checks++;
    if (n_rise != 1 || n_fall != 1) begin
      errors++; $display("FAIL press_pulses: got rise=%0d fall=%0d want 1/1", n_rise, n_fall);
    end
`endif
  endtask

  task automatic test_chatter();
    logic [W-1:0] e;
    int hits;
    hits = 0;
    fork
      begin
        align();
        for (int j = 0; j < 10; j++) hold((j % 2) == 0, 10);
        button = 1'b0;
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL chatter_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL chatter_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if ((|obs[0 +: OW]) || (|obs[2*OW +: OW])) hits++;
        end
      end
    join
    checks++;
    if (hits != 0) begin
      errors++; $display("FAIL chatter_quiet: got %0d active cycles want 0", hits);
    end
  endtask

  task automatic test_slow_chatter();
    logic [W-1:0] e;
    int hits;
    hits = 0;
    fork
      begin
        align();
        repeat (4) begin
          hold(1'b1, 20);
          hold(1'b0, 20);
        end
      end
      begin
        for (int c = 0; c < 22; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL slow_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL slow_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if ((|obs[0 +: OW]) || (|obs[2*OW +: OW])) hits++;
        end
      end
    join
    checks++;
    if (hits != 0) begin
      errors++; $display("FAIL slow_quiet: got %0d active cycles want 0", hits);
    end
  endtask

  task automatic test_glitch_train();
    logic [W-1:0] e;
    int k, e_rise;
    logic prev4;
    k = -1; e_rise = -1;
    prev4 = y4;
    fork
      begin
        @(posedge clk); #1;
        hold(1'b1, 5);
        hold(1'b0, 8);
        hold(1'b1, 27);
        hold(1'b0, 20);
        button = 1'b1;
        @(posedge clk); #1 k = ecnt;
        #90 button = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL glitch_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL glitch_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if (y4 && !prev4 && e_rise < 0) e_rise = ecnt;
          prev4 = y4;
        end
      end
    join
    checks++;
    if (e_rise - k != 5) begin
      errors++; $display("FAIL glitch_first_rise: got %0d edges after hold want 5", e_rise - k);
    end
  endtask

  task automatic test_sweep_latency();
    logic [W-1:0] e;
    int k, e1, e8;
    logic prev1, prev8;
    k = -1; e1 = -1; e8 = -1;
    prev1 = y1; prev8 = y8;
    fork
      begin
        align();
        button = 1'b1;
        @(posedge clk); #1 k = ecnt;
        #95 button = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL sweep_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL sweep_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if (y1 && !prev1 && e1 < 0) e1 = ecnt;
          if (y8 && !prev8 && e8 < 0) e8 = ecnt;
          prev1 = y1;
          prev8 = y8;
        end
      end
    join
    checks++;
    if (e1 - k != SYNC) begin
      errors++; $display("FAIL sweep_latency_dc1: got %0d edges want %0d", e1 - k, SYNC);
    end
    checks++;
    if (e8 - k != SYNC + 7) begin
      errors++; $display("FAIL sweep_latency_dc8: got %0d edges want %0d", e8 - k, SYNC + 7);
    end
  endtask

  task automatic test_sweep_window();
    logic [W-1:0] e;
    int rise_a, rise_b;
    logic prev8, phase_b;
    rise_a = 0; rise_b = 0; phase_b = 1'b0;
    prev8 = y8;
    fork
      begin
        align();
        hold(1'b1, 70);
        hold(1'b0, 120);
        phase_b = 1'b1;
        hold(1'b1, 80);
        button = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL window_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL window_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if (y8 && !prev8) begin
            if (phase_b) rise_b++;
            else rise_a++;
          end
          prev8 = y8;
        end
      end
    join
    checks++;
    if (rise_a != 0) begin
      errors++; $display("FAIL window_70ns_reject: got %0d rises want 0", rise_a);
    end
    checks++;
    if (rise_b != 1) begin
      errors++; $display("FAIL window_80ns_accept: got %0d rises want 1", rise_b);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    int k, e_rise;
    logic prev4, armed;
    k = -1; e_rise = -1; armed = 1'b0;
    prev4 = y4;
    fork
      begin
        align();
        button = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk); #1 button = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (y4 !== 1'b1) begin
          errors++; $display("FAIL async_pre: got result=%b want 1", y4);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
          errors++; $display("FAIL async_clear: got %b want %b", obs, {W{1'b0}});
        end
        button = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        armed = 1'b1;
        @(posedge clk); #1 k = ecnt;
        #115 button = 1'b0;
      end
      begin
        for (int c = 0; c < 45; c++) begin
          @(negedge clk);
          if (reset) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL async_sb: no expected entry at %0t", $time);
            end else begin
              e = exp_q.pop_front();
              if (obs !== e) begin
                errors++; $display("FAIL async_sb: got %b want %b at %0t", obs, e, $time);
              end
            end
          end
          if (armed && y4 && !prev4 && e_rise < 0) e_rise = ecnt;
          prev4 = y4;
        end
      end
    join
    checks++;
    if (e_rise - k != 5) begin
      errors++; $display("FAIL async_recover_latency: got %0d edges want 5", e_rise - k);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_press();
    test_chatter();
    test_slow_chatter();
    test_glitch_train();
    test_sweep_latency();
    test_sweep_window();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_ckt.md
Name: debounce_ckt

Overview:
Push-button debouncer. It synchronises a raw mechanical button input into the clk domain. It drives a clean level output `result` that changes only after the synchronised input has held a new level for a programmable number of consecutive clock cycles. It sits between board-level button pins and user logic. Glitches and contact bounce shorter than the debounce window are discarded.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `button`; legal range 2 or more.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples of the new level required before `result` changes; legal range 1 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- button  input  1  raw, asynchronous, bouncing button level (1 = pressed).
- result  output  1  debounced button level, registered.
- result_rise  output  1  only with DEBOUNCE_EDGE_EN: one-cycle pulse when `result` goes 0->1.
- result_fall  output  1  only with DEBOUNCE_EDGE_EN: one-cycle pulse when `result` goes 1->0.

Behaviour:
- Reset (reset=0): asynchronously clears to 0 all synchroniser flops, the counter, `result`, `result_rise` and `result_fall`. No clock edge is needed. State is held while reset stays low.
- Synchroniser: `button` passes through a SYNC_STAGES-deep flop chain. The last stage is called b_s. No other logic samples `button` directly.
- Per rising edge, in priority order:
  - If b_s == result: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: result <= b_s, cnt <= 0.
  - Else: cnt <= cnt+1.
- Any sample of b_s that matches `result` during counting restarts the window. Partial progress never carries over.
- Latency: let edge k be the first edge that samples the new `button` level, with the level then held. `result` changes on edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults this is 5 edges, i.e. 50 ns at 100 MHz.
- Rejection: a level held for fewer than DEBOUNCE_CYCLES consecutive b_s samples never reaches `result`. With defaults, pulses of 30 ns or less at a 10 ns clock are always rejected.
- Symmetry: press and release use the same window and latency.
- DEBOUNCE_CYCLES=1: `result` follows b_s with one extra register, and cnt stays 0.
- The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- Reset mid-count or while result=1: everything clears to 0 immediately. After release, a still-pressed button reappears on `result` after the full latency, counted from the first edge after deassertion.
- No combinational path from `button` to any output.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN.
- Defined:
  - `result_rise` and `result_fall` exist and are registered.
  - Each is high for exactly the one cycle in which `result` has just taken its new value, i.e. aligned with `result`.
  - Both reset to 0 and are never high together.
- Undefined: both ports and their logic are absent. `result` behaviour is identical in both builds.

Test Plan:
1. 10 ns clk, reset low then high; button 0->1 held 90 ns, then 0 -> `result` rises exactly 5 edges after the first sampling edge, stays 1, then falls 5 edges after release. With EDGE_EN, one `result_rise` pulse and one `result_fall` pulse.
2. Chatter: button alternates every 10 ns for 100 ns, then settles at 0 -> `result` stays 0 throughout, and no edge pulses.
3. Button alternates 20 ns high / 20 ns low, four times -> `result` stays 0.
4. Button 1 for 5 ns, 0 for 8 ns, 1 for 27 ns, 0, then 1 held 100 ns -> `result` stays 0 until the final hold. It then rises 5 edges after that hold begins.
5. With result=1 and counting toward release, assert reset asynchronously between edges -> `result`=0 immediately. Release reset with button held 1 -> `result` returns to 1 after 5 edges.
6. Parameter sweep DEBOUNCE_CYCLES=1 and 8 with a 100 ns press -> latency is SYNC_STAGES+DEBOUNCE_CYCLES-1 edges. For 8: a 70 ns pulse is rejected and an 80 ns pulse is accepted.
